// File: rtl/weight_streamer.sv
// weight_streamer: answers tile get_weights requests with one weight row at a time, walking
// layer-0 rows then layer-1 rows. Optional one-row prefetch buffer: WEIGHT_STREAMER_PREFETCH_EN.
module weight_streamer #(
    parameter int NUM_NEURONS = 128,
    parameter int IMG_SZ      = 784,
    parameter int OUTPUT_SZ   = 10,
    parameter int TOTAL_ROWS  = IMG_SZ + NUM_NEURONS,
    parameter int ADDR_W      = $clog2(TOTAL_ROWS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   get_weights,
    output logic                   mem_rd,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [NUM_NEURONS-1:0] mem_rdata,
    output logic [NUM_NEURONS-1:0] weights,
    output logic                   weights_valid,
    output logic                   layer,
    output logic                   last_row,
    output logic                   pass_done,
    output logic                   busy,
    output logic                   req_drop
);

    localparam logic [ADDR_W-1:0]      LAST_ROW_ADDR = ADDR_W'(TOTAL_ROWS - 1);
    localparam logic [ADDR_W-1:0]      L1_BASE       = ADDR_W'(IMG_SZ);
    localparam logic [NUM_NEURONS-1:0] L1_MASK       =
        {{(NUM_NEURONS - OUTPUT_SZ){1'b0}}, {OUTPUT_SZ{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_CAPT  = 2'd2,
        S_DELIV = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] row_ptr;

    // Layer-1 rows carry only OUTPUT_SZ meaningful bits; the rest are forced to zero.
    function automatic logic [NUM_NEURONS-1:0] mask_row(input logic [NUM_NEURONS-1:0] row,
                                                        input logic                   is_l1);
        return is_l1 ? (row & L1_MASK) : row;
    endfunction

    function automatic logic [ADDR_W-1:0] next_row(input logic [ADDR_W-1:0] r);
        return (r == LAST_ROW_ADDR) ? '0 : r + ADDR_W'(1);
    endfunction

`ifdef WEIGHT_STREAMER_PREFETCH_EN
    logic [NUM_NEURONS-1:0] buf_data;
    logic [ADDR_W-1:0]      buf_row;
    logic                   buf_full;
    logic                   pending;
    logic                   deliver;

    assign deliver = buf_full && (get_weights || pending) && !start;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
`ifdef WEIGHT_STREAMER_PREFETCH_EN
        // The fetch FSM only fills the buffer; delivery comes straight out of the buffer.
        case (state)
            S_IDLE: begin
                if ((deliver && buf_row != LAST_ROW_ADDR) ||
                    (!buf_full && (pending || get_weights)))
                    state_nxt = S_READ;
            end
            S_READ:  state_nxt = S_CAPT;
            S_CAPT:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (start) state_nxt = S_READ;
`else
        case (state)
            S_IDLE:  if (get_weights) state_nxt = S_READ;
            S_READ:  state_nxt = S_CAPT;
            S_CAPT:  state_nxt = S_DELIV;
            S_DELIV: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (start) state_nxt = get_weights ? S_READ : S_IDLE;
`endif
    end

    always_comb begin
        busy = (state != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rd        <= 1'b0;
            mem_addr      <= '0;
            row_ptr       <= '0;
            weights       <= '0;
            weights_valid <= 1'b0;
            layer         <= 1'b0;
            last_row      <= 1'b0;
            pass_done     <= 1'b0;
            req_drop      <= 1'b0;
`ifdef WEIGHT_STREAMER_PREFETCH_EN
            buf_data      <= '0;
            buf_row       <= '0;
            buf_full      <= 1'b0;
            pending       <= 1'b0;
`endif
        end else begin
            mem_rd    <= (state_nxt == S_READ);
            if (state_nxt == S_READ) mem_addr <= start ? '0 : row_ptr;
            pass_done <= weights_valid && last_row;
`ifdef WEIGHT_STREAMER_PREFETCH_EN
            weights_valid <= deliver;
            req_drop      <= get_weights && pending && !start;
            if (start) begin
                row_ptr  <= '0;
                buf_full <= 1'b0;
                pending  <= get_weights;
            end else begin
                if (state == S_CAPT) begin
                    buf_data <= mask_row(mem_rdata, row_ptr >= L1_BASE);
                    buf_row  <= row_ptr;
                    buf_full <= 1'b1;
                    row_ptr  <= next_row(row_ptr);
                end
                if (deliver) begin
                    weights  <= buf_data;
                    layer    <= (buf_row >= L1_BASE);
                    last_row <= (buf_row == LAST_ROW_ADDR);
                    buf_full <= 1'b0;
                    pending  <= 1'b0;
                end else if (get_weights) begin
                    pending  <= 1'b1;
                end
            end
`else
            weights_valid <= 1'b0;
            req_drop      <= get_weights && busy && !start;
            if (start) begin
                row_ptr <= '0;
            end else begin
                if (state == S_CAPT) begin
                    weights       <= mask_row(mem_rdata, row_ptr >= L1_BASE);
                    layer         <= (row_ptr >= L1_BASE);
                    last_row      <= (row_ptr == LAST_ROW_ADDR);
                    weights_valid <= 1'b1;
                end
                if (state == S_DELIV) row_ptr <= next_row(row_ptr);
            end
`endif
        end
    end

endmodule

// File: tb/tb_weight_streamer.sv
// Self-checking bench for weight_streamer: synchronous memory model plus a row scoreboard.
module tb_weight_streamer;

    localparam int NUM_NEURONS = 128;
    localparam int IMG_SZ      = 784;
    localparam int OUTPUT_SZ   = 10;
    localparam int TOTAL_ROWS  = IMG_SZ + NUM_NEURONS;
    localparam int ADDR_W      = 10;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic                   get_weights;
    logic                   mem_rd;
    logic [ADDR_W-1:0]      mem_addr;
    logic [NUM_NEURONS-1:0] mem_rdata = '0;
    logic [NUM_NEURONS-1:0] weights;
    logic                   weights_valid;
    logic                   layer;
    logic                   last_row;
    logic                   pass_done;
    logic                   busy;
    logic                   req_drop;

    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_q[$];
    int   mon_row;
    logic pd_exp = 1'b0;

    always #5 clk = ~clk;

    weight_streamer #(
        .NUM_NEURONS(NUM_NEURONS),
        .IMG_SZ     (IMG_SZ),
        .OUTPUT_SZ  (OUTPUT_SZ)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .get_weights  (get_weights),
        .mem_rd       (mem_rd),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .weights      (weights),
        .weights_valid(weights_valid),
        .layer        (layer),
        .last_row     (last_row),
        .pass_done    (pass_done),
        .busy         (busy),
        .req_drop     (req_drop)
    );

    function automatic logic [NUM_NEURONS-1:0] row_data(input int a);
        logic [31:0] h;
        if (a == 0) return {16{8'hA5}};
        h = ((32'(a) + 32'd1) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
        return {h, ~h, h ^ 32'hFFFF0000, h + 32'd7};
    endfunction

    function automatic logic [NUM_NEURONS-1:0] exp_row(input int a);
        logic [NUM_NEURONS-1:0] d;
        d = row_data(a);
        if (a >= IMG_SZ)
            for (int i = OUTPUT_SZ; i < NUM_NEURONS; i++) d[i] = 1'b0;
        return d;
    endfunction

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= row_data(int'(mem_addr));
    end

    always @(negedge clk) begin
        if (rst) begin
            pd_exp = 1'b0;
        end else begin
            n_cmp++;
            if (pass_done !== pd_exp) begin
                n_err++;
                $display("FAIL pass_done @%0t: got %b want %b", $time, pass_done, pd_exp);
            end
            pd_exp = 1'b0;
            if (weights_valid === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_valid @%0t: got weights_valid=1 want 0", $time);
                end else begin
                    mon_row = exp_q.pop_front();
                    if (weights !== exp_row(mon_row) || layer !== (mon_row >= IMG_SZ) ||
                        last_row !== (mon_row == TOTAL_ROWS - 1)) begin
                        n_err++;
                        $display("FAIL row_%0d @%0t: got w=%h layer=%b last=%b want w=%h layer=%b last=%b",
                                 mon_row, $time, weights, layer, last_row, exp_row(mon_row),
                                 mon_row >= IMG_SZ, mon_row == TOTAL_ROWS - 1);
                    end
                    pd_exp = (mon_row == TOTAL_ROWS - 1);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; get_weights = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({mem_rd, weights_valid, layer, last_row, pass_done, busy, req_drop} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {mem_rd, weights_valid, layer, last_row, pass_done, busy, req_drop});
        end
        n_cmp++;
        if (mem_addr !== '0 || weights !== '0) begin
            n_err++;
            $display("FAIL reset_data: got addr=%0d w=%h want 0", mem_addr, weights);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || mem_rd !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: got busy=%b mem_rd=%b want 0 0", busy, mem_rd);
        end
    endtask

`ifdef WEIGHT_STREAMER_PREFETCH_EN
    task automatic test_prefetch();
        bit seen;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (mem_rd !== 1'b1 || mem_addr !== '0) begin
            n_err++;
            $display("FAIL pf_start_read: got rd=%b addr=%0d want 1 0", mem_rd, mem_addr);
        end
        repeat (9) @(negedge clk);
        exp_q.push_back(0);
        get_weights = 1'b1;
        @(negedge clk);
        get_weights = 1'b0;
        n_cmp++;
        if (weights_valid !== 1'b1) begin
            n_err++;
            $display("FAIL pf_latency: got weights_valid=%b want 1", weights_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            if (mem_rd === 1'b1) begin
                seen = 1'b1;
                n_cmp++;
                if (mem_addr !== ADDR_W'(1)) begin
                    n_err++;
                    $display("FAIL pf_next_addr: got %0d want 1", mem_addr);
                end
            end else begin
                @(negedge clk);
            end
        end
        if (!seen) begin
            n_cmp++; n_err++;
            $display("FAIL pf_prefetch_timeout: got no mem_rd want mem_rd within 4 cycles");
        end
        exp_q.push_back(1);
        get_weights = 1'b1;
        @(negedge clk);
        get_weights = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (weights_valid === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL pf_pending: got no weights_valid want delivery within 8 cycles");
        end
        @(negedge clk);
    endtask
`else
    task automatic do_fetch(input int row);
        exp_q.push_back(row);
        get_weights = 1'b1;
        @(negedge clk);
        get_weights = 1'b0;
        n_cmp++;
        if (mem_rd !== 1'b1 || mem_addr !== ADDR_W'(row)) begin
            n_err++;
            $display("FAIL fetch_addr_%0d: got rd=%b addr=%0d want rd=1 addr=%0d", row, mem_rd, mem_addr, row);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (weights_valid !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL fetch_latency_%0d: got valid=%b busy=%b want 1 1", row, weights_valid, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_first();
        n_cmp++;
        if (mem_rd !== 1'b0) begin
            n_err++;
            $display("FAIL idle_mem_rd: got %b want 0", mem_rd);
        end
        do_fetch(0);
    endtask

    task automatic test_stream();
        for (int r = 1; r < TOTAL_ROWS; r++) do_fetch(r);
        do_fetch(0);
    endtask

    task automatic test_drop();
        exp_q.push_back(1);
        get_weights = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (mem_addr !== ADDR_W'(1)) begin
            n_err++;
            $display("FAIL drop_addr: got %0d want 1", mem_addr);
        end
        @(negedge clk);
        get_weights = 1'b0;
        n_cmp++;
        if (req_drop !== 1'b1) begin
            n_err++;
            $display("FAIL drop_busy: got req_drop=%b want 1", req_drop);
        end
        @(negedge clk);
        n_cmp++;
        if (weights_valid !== 1'b1 || req_drop !== 1'b0) begin
            n_err++;
            $display("FAIL drop_deliver: got valid=%b drop=%b want 1 0", weights_valid, req_drop);
        end
        get_weights = 1'b1;
        @(negedge clk);
        get_weights = 1'b0;
        n_cmp++;
        if (req_drop !== 1'b1) begin
            n_err++;
            $display("FAIL drop_deliv_state: got req_drop=%b want 1", req_drop);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || mem_rd !== 1'b0) begin
            n_err++;
            $display("FAIL drop_not_accepted: got busy=%b rd=%b want 0 0", busy, mem_rd);
        end
        do_fetch(2);
    endtask

    task automatic test_start_read();
        do_fetch(3);
        do_fetch(4);
        get_weights = 1'b1;
        @(negedge clk);
        get_weights = 1'b0;
        n_cmp++;
        if (mem_rd !== 1'b1 || mem_addr !== ADDR_W'(5)) begin
            n_err++;
            $display("FAIL start_read_addr: got rd=%b addr=%0d want 1 5", mem_rd, mem_addr);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || mem_rd !== 1'b0 || req_drop !== 1'b0) begin
            n_err++;
            $display("FAIL start_abort: got busy=%b rd=%b drop=%b want 0 0 0", busy, mem_rd, req_drop);
        end
        repeat (4) @(negedge clk);
        do_fetch(0);
    endtask

    task automatic test_start_get_busy();
        get_weights = 1'b1;
        @(negedge clk);
        get_weights = 1'b0;
        @(negedge clk);
        exp_q.push_back(0);
        start = 1'b1;
        get_weights = 1'b1;
        @(negedge clk);
        start = 1'b0;
        get_weights = 1'b0;
        n_cmp++;
        if (mem_rd !== 1'b1 || mem_addr !== '0) begin
            n_err++;
            $display("FAIL start_get_addr: got rd=%b addr=%0d want 1 0", mem_rd, mem_addr);
        end
        @(negedge clk);
        n_cmp++;
        if (req_drop !== 1'b0) begin
            n_err++;
            $display("FAIL start_get_drop: got req_drop=%b want 0", req_drop);
        end
        @(negedge clk);
        n_cmp++;
        if (weights_valid !== 1'b1) begin
            n_err++;
            $display("FAIL start_get_deliver: got valid=%b want 1", weights_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midfetch();
        get_weights = 1'b1;
        @(negedge clk);
        get_weights = 1'b0;
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (mem_rd !== 1'b0 || busy !== 1'b0 || mem_addr !== '0) begin
            n_err++;
            $display("FAIL async_reset: got rd=%b busy=%b addr=%0d want 0 0 0", mem_rd, busy, mem_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        do_fetch(0);
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
`ifdef WEIGHT_STREAMER_PREFETCH_EN
        test_prefetch();
`else
        test_first();
        test_stream();
        test_drop();
        test_start_read();
        test_start_get_busy();
        test_reset_midfetch();
`endif
        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover_rows: got %0d undelivered want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
